// File: rtl/seq_collector.sv
// Result sink for the sequence generator: buffers valid float terms in a FIFO,
// latches the first terminating error code and serves a one-cycle-latency read port.
module seq_collector #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          R_I,
  input  logic [31:0]   dataIn,
  input  logic [1:0]    err,
  input  logic          rd_en,
  output logic [31:0]   rd_data,
  output logic          rd_valid,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full,
  output logic          done,
  output logic [1:0]    err_code,
  output logic          dropped,
  output logic [1:0]    dbg_state
);

  // Handshake: a term is offered whenever R_I is high (no backpressure to the
  // generator); a read is accepted when rd_en is high and the FIFO is not empty,
  // and its word appears with a one-cycle rd_valid pulse on the following cycle.

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  localparam logic [AW:0] LP_FULL = DEPTH[AW:0];

  state_t            r_state;
  state_t            w_next_state;
  logic [31:0]       r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [AW:0]       r_count;
  logic [31:0]       r_rd_data;
  logic              r_rd_valid;
  logic [1:0]        r_err_code;
  logic              r_dropped;

  logic              w_flush;
  logic              w_in_done;
  logic              w_empty;
  logic              w_full;
  logic              w_wr_req;
  logic              w_rd_acc;
  logic              w_wr_acc;
  logic              w_drop;
  logic              w_err_cap;

  assign w_flush   = reset | clr;
  assign w_in_done = (r_state == S_DONE);
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == LP_FULL);

  assign w_wr_req  = R_I & (err == 2'b00) & ~w_in_done;
  assign w_rd_acc  = rd_en & ~w_empty;
  // A full FIFO still takes a write when a read frees a slot on the same edge.
  assign w_wr_acc  = w_wr_req & (~w_full | w_rd_acc);
  assign w_drop    = w_wr_req & w_full & ~w_rd_acc;
  assign w_err_cap = R_I & (err != 2'b00) & ~w_in_done;

  always_ff @(posedge clk) begin
    if (w_flush) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (R_I) w_next_state = (err != 2'b00) ? S_DONE : S_COLLECT;
      end
      S_COLLECT: begin
        if (R_I && (err != 2'b00)) w_next_state = S_DONE;
      end
      S_DONE:  w_next_state = S_DONE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Storage carries no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (!w_flush && w_wr_acc) r_mem[r_wptr] <= dataIn;
  end

  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_err_code <= 2'b00;
      r_dropped  <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
      if (w_rd_acc) begin
        r_rd_data <= r_mem[r_rptr];
        r_rptr    <= r_rptr + 1'b1;
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_err_cap) r_err_code <= err;
      if (w_drop)    r_dropped  <= 1'b1;
    end
  end

  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign count     = r_count;
  assign empty     = w_empty;
  assign full      = w_full;
  assign done      = w_in_done;
  assign err_code  = r_err_code;
  assign dropped   = r_dropped;
  assign dbg_state = r_state;

endmodule
